// File: rtl/interconnect_matrix.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | interconnect_matrix                                                      |
// | Serially programmed crossbar routing fabric/feedback wires to LUT inputs.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module interconnect_matrix #(
  parameter int N_IN  = 16,
  parameter int N_FB  = 8,
  parameter int N_OUT = 4
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             prgm_b,
  input  logic             CLB_prgm_b,
  input  logic             cfg_en,
  input  logic             cfg_din,
  input  logic [N_IN-1:0]  I,
  input  logic [N_FB-1:0]  IQ,
  output logic [N_OUT-1:0] lut_inp,
  output logic [N_OUT-1:0] lut_inp_en,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam int SEL_W = $clog2(N_IN + N_FB + 1);
  localparam int TOT   = N_OUT * SEL_W;
  localparam int CNT_W = $clog2(TOT + 2);
  localparam int SRC_W = 1 << SEL_W;

  localparam logic [SEL_W-1:0] c_n_src    = SEL_W'(N_IN + N_FB);
  localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(TOT);
  localparam logic [CNT_W-1:0] c_cnt_sat  = CNT_W'(TOT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_prgm_b;
  logic [TOT-1:0]     r_active;
  logic [TOT-1:0]     r_shadow;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_have_cfg;
  logic [N_OUT-1:0]   r_lut;
  logic [N_OUT-1:0]   r_lut_en;
  logic               r_done;
  logic               r_err;

  logic               w_fall;
  logic               w_rise;
  logic               w_cnt_ok;
  logic               w_enter_load;
  logic               w_route_on;
  logic [SRC_W-1:0]   w_src;
  logic [N_OUT-1:0]   w_route;
  logic [N_OUT-1:0]   w_valid;

  assign w_fall       = r_prgm_b & ~prgm_b;
  assign w_rise       = ~r_prgm_b & prgm_b;
  assign w_cnt_ok     = (r_cnt == c_cnt_full);
  assign w_enter_load = (r_state != S_LOAD) && w_fall;
  assign w_route_on   = (r_state == S_ACTIVE) && r_prgm_b;

  // Padding above the real sources reads as 0, so an out-of-range select is harmless.
  assign w_src = SRC_W'({IQ, I});

  for (genvar k = 0; k < N_OUT; k++) begin : g_route
    logic [SEL_W-1:0] w_sel;
    assign w_sel      = r_active[k*SEL_W +: SEL_W];
    assign w_valid[k] = (w_sel < c_n_src);
    assign w_route[k] = w_valid[k] & w_src[w_sel];
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fall) w_state_nxt = S_LOAD;
      end
      S_ACTIVE: begin
        if (w_fall) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (w_rise) begin
          if (w_cnt_ok || r_have_cfg) w_state_nxt = S_ACTIVE;
          else                        w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_prgm_b   <= 1'b1;
      r_active   <= '1;
      r_shadow   <= '0;
      r_cnt      <= '0;
      r_have_cfg <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_prgm_b <= prgm_b;
      if (w_enter_load) begin
        r_cnt      <= '0;
        r_err      <= 1'b0;
        r_have_cfg <= (r_state == S_ACTIVE);
      end else if (r_state == S_LOAD) begin
        // The commit edge takes priority over any bit presented on it.
        if (w_rise) begin
          if (w_cnt_ok) begin
            r_active <= r_shadow;
            r_done   <= 1'b1;
            r_err    <= 1'b0;
          end else begin
            r_err <= 1'b1;
          end
        end else if (cfg_en && !CLB_prgm_b) begin
          r_shadow <= {r_shadow[TOT-2:0], cfg_din};
          if (r_cnt != c_cnt_sat) r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Outputs freeze in LOAD so a partial configuration never reaches the LUT.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_lut    <= '0;
      r_lut_en <= '0;
    end else if (w_route_on) begin
      r_lut    <= w_route;
      r_lut_en <= w_valid;
    end else if (r_state == S_IDLE) begin
      r_lut    <= '0;
      r_lut_en <= '0;
    end
  end

  assign lut_inp    = r_lut;
  assign lut_inp_en = r_lut_en;
  assign cfg_done   = r_done;
  assign cfg_err    = r_err;

endmodule
`default_nettype wire

// File: doc/interconnect_matrix.md
Name: interconnect_matrix

Overview:
Parametrised, serially programmed routing crossbar feeding the LUT inputs of one CLB. Each of N_OUT LUT inputs selects one of N_IN fabric wires or N_FB CLB feedback (loop) outputs. Selections are loaded as a bitstream into a shadow chain while prgm_b is low and committed atomically when prgm_b rises. Outputs are registered and carry a per-output enable, so an unused input drives a defined 0 instead of z.

Parameters:
N_IN, 16, number of fabric input wires (I).
N_FB, 8, number of CLB feedback/loop inputs (IQ).
N_OUT, 4, number of LUT inputs driven.
SEL_W, derived localparam = $clog2(N_IN+N_FB+1), width of one select field. It is 5 at the defaults.
TOT, derived localparam = N_OUT*SEL_W, total configuration bits. It is 20 at the defaults.

Ports:
clk  input  1  fabric/config clock; all state changes on its rising edge.
reset_b  input  1  asynchronous, active-low reset.
prgm_b  input  1  global program strobe: 0 = programming mode, 1 = run mode.
CLB_prgm_b  input  1  active-low CLB select; config bits are accepted only when this is 0.
cfg_en  input  1  shift enable for cfg_din.
cfg_din  input  1  serial configuration bit.
I  input  N_IN  fabric input wires.
IQ  input  N_FB  CLB feedback inputs.
lut_inp  output  N_OUT  registered routed LUT inputs.
lut_inp_en  output  N_OUT  1 = the select for that output is valid and the output is driven.
cfg_done  output  1  a valid configuration is active.
cfg_err  output  1  the last commit was rejected because of a bit-count mismatch.

Behaviour:
- Reset (reset_b = 0, asynchronous):
  - state goes to IDLE.
  - Active select registers are set to all-ones (unused); shadow register is cleared to 0; bit counter is cleared to 0.
  - lut_inp = 0, lut_inp_en = 0, cfg_done = 0, cfg_err = 0.
  - Reset asserted mid-load discards the partial load.
- prgm_b is sampled into a register; edges are detected from the sampled value.
- States: IDLE (unconfigured), LOAD, ACTIVE.
  - IDLE: on a prgm_b falling edge, go to LOAD.
  - ACTIVE: on a prgm_b falling edge, go to LOAD and remember that a configuration already exists.
  - On entering LOAD: bit counter clears to 0 and cfg_err clears to 0. cfg_done keeps its value.
  - In LOAD, when cfg_en=1 and CLB_prgm_b=0:
    - shadow <= {shadow[TOT-2:0], cfg_din}.
    - Counter increments and saturates at TOT+1.
  - In LOAD, when cfg_en=1 and CLB_prgm_b=1: the bit is ignored and the counter holds.
  - prgm_b rising edge in LOAD with counter == TOT:
    - Active selects <= shadow in the same edge.
    - cfg_done=1, cfg_err=0, state goes to ACTIVE.
  - prgm_b rising edge in LOAD with counter != TOT (short or over-long load):
    - cfg_err=1 and active selects are unchanged.
    - State returns to ACTIVE if a configuration existed, otherwise to IDLE.
- Field mapping:
  - Output k uses active[(k+1)*SEL_W-1 : k*SEL_W].
  - The first bit shifted in lands in the MSB of the output N_OUT-1 field.
- Select decode:
  - 0..N_IN-1 selects I[sel].
  - N_IN..N_IN+N_FB-1 selects IQ[sel-N_IN].
  - Any larger value is unused.
- Routing:
  - Routing is active only in ACTIVE with sampled prgm_b=1.
  - Each cycle, lut_inp[k] <= the selected bit and lut_inp_en[k] <= (sel valid). Latency is 1 clk from an I/IQ change to lut_inp.
  - An unused select gives lut_inp[k]=0 and lut_inp_en[k]=0.
- During LOAD, lut_inp and lut_inp_en hold their last values (routing is frozen; no glitching on partial config).
- In IDLE, lut_inp=0 and lut_inp_en=0.
- First routed value appears 1 clk after the commit edge, which uses the new selects.
- CLB_prgm_b does not affect run-mode routing.

Test Plan:
- Reset check: assert reset_b=0 mid-cycle -> lut_inp=0, lut_inp_en=0, cfg_done=0, cfg_err=0 immediately; state IDLE; toggling I has no effect on the outputs.
- Valid load and route:
  - Stimulus: prgm_b=0, CLB_prgm_b=0; shift 20 bits, MSB first, for selects out3=0, out2=5, out1=16, out0=23; raise prgm_b.
  - Required: cfg_done=1 after the commit edge.
  - Then drive I=16'h0021, IQ=8'h80 -> lut_inp=4'b1101 and lut_inp_en=4'hF one clk later.
- Short load: from the configured state of the valid-load scenario, shift only 19 bits and raise prgm_b -> cfg_err=1, cfg_done stays 1, and routing still gives 4'b1101 for the same I/IQ.
- Unused select: load out0=31 and the others as in the valid-load scenario -> lut_inp[0]=0, lut_inp_en[0]=0, lut_inp_en=4'hE.
- Deselected CLB: CLB_prgm_b=1 during 20 cfg_en pulses from IDLE, then raise prgm_b -> counter stays 0, cfg_err=1, state IDLE, outputs remain 0.
- Over-long load: shift 21 bits -> cfg_err=1 and the prior configuration is retained.
- Reset mid-load: pulse reset_b after 10 bits -> all outputs 0 and IDLE. A subsequent full 20-bit load commits correctly.
